// File: rtl/life_grid_stepper.sv
// life_grid_stepper: double-buffered WIDTH x HEIGHT Life grid with
// programmable birth/survive masks. One generation per step command, one
// row per clock. Build option LIFE_WRAP_EN selects a toroidal grid;
// without it every neighbour outside the grid counts as dead.
//
// Handshake: a load row is consumed on any rising edge where load_valid
// and load_ready are both high; load_ready is high only in IDLE. A step is
// taken on an IDLE edge with step high and load_valid low (the load wins a
// tie). Anything presented while busy is dropped, never queued.
module life_grid_stepper #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int AW     = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_row,
  input  logic             step,
  input  logic [8:0]       rule_birth,
  input  logic [8:0]       rule_survive,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_row,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [15:0]      gen_count
);

`ifdef LIFE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_bank0 [HEIGHT];
  logic [WIDTH-1:0] r_bank1 [HEIGHT];
  logic             r_sel;
  logic [AW-1:0]    r_load_ptr;
  logic [AW-1:0]    r_row;
  logic [8:0]       r_birth;
  logic [8:0]       r_survive;
  logic             r_equal;
  logic             r_stable;
  logic             r_done;
  logic [15:0]      r_gen;

  logic [WIDTH-1:0] w_cur [HEIGHT];
  logic [WIDTH-1:0] w_above;
  logic [WIDTH-1:0] w_mid;
  logic [WIDTH-1:0] w_below;
  logic [WIDTH+1:0] w_ea;
  logic [WIDTH+1:0] w_em;
  logic [WIDTH+1:0] w_eb;
  logic [3:0]       w_n [WIDTH];
  logic [WIDTH-1:0] w_new;
  logic             w_last;
  logic             w_accept;
  logic             w_load;

  assign w_last   = (r_row == AW'(HEIGHT - 1));
  assign w_accept = (r_state == S_IDLE) && step && !load_valid;
  assign w_load   = (r_state == S_IDLE) && load_valid;

  // Current generation as selected by the bank pointer
  always_comb begin
    for (int r = 0; r < HEIGHT; r++) begin
      w_cur[r] = r_sel ? r_bank1[r] : r_bank0[r];
    end
  end

  // Neighbour rows of the row being computed; edges are dead or wrapped
  always_comb begin
    w_mid = w_cur[r_row];
    if (r_row == '0) begin
      w_above = WRAP ? w_cur[HEIGHT-1] : '0;
    end else begin
      w_above = w_cur[r_row - AW'(1)];
    end
    if (w_last) begin
      w_below = WRAP ? w_cur[0] : '0;
    end else begin
      w_below = w_cur[r_row + AW'(1)];
    end
  end

  // Pad each row with one column on both sides: bit 0 is column -1,
  // bit WIDTH+1 is column WIDTH
  assign w_ea = {(WRAP ? w_above[0] : 1'b0), w_above, (WRAP ? w_above[WIDTH-1] : 1'b0)};
  assign w_em = {(WRAP ? w_mid[0]   : 1'b0), w_mid,   (WRAP ? w_mid[WIDTH-1]   : 1'b0)};
  assign w_eb = {(WRAP ? w_below[0] : 1'b0), w_below, (WRAP ? w_below[WIDTH-1] : 1'b0)};

  // Neighbour count and rule lookup for every column of the row
  always_comb begin
    w_new = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_n[c] = 4'(w_ea[c]) + 4'(w_ea[c+1]) + 4'(w_ea[c+2])
             + 4'(w_em[c])                 + 4'(w_em[c+2])
             + 4'(w_eb[c]) + 4'(w_eb[c+1]) + 4'(w_eb[c+2]);
      w_new[c] = w_em[c+1] ? r_survive[w_n[c]] : r_birth[w_n[c]];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: IDLE -> CALC (HEIGHT cycles) -> COMMIT -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_CALC;
      S_CALC:   if (w_last)   w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Grid banks, loading, row computation and commit bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) begin
        r_bank0[r] <= '0;
        r_bank1[r] <= '0;
      end
      r_sel      <= 1'b0;
      r_load_ptr <= '0;
      r_row      <= '0;
      r_birth    <= '0;
      r_survive  <= '0;
      r_equal    <= 1'b0;
      r_stable   <= 1'b0;
      r_done     <= 1'b0;
      r_gen      <= '0;
    end else begin
      r_done <= (r_state == S_COMMIT);
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            if (r_sel) r_bank1[r_load_ptr] <= load_row;
            else       r_bank0[r_load_ptr] <= load_row;
            r_load_ptr <= (r_load_ptr == AW'(HEIGHT - 1)) ? '0 : r_load_ptr + AW'(1);
          end else if (w_accept) begin
            r_birth   <= rule_birth;
            r_survive <= rule_survive;
            r_row     <= '0;
            r_equal   <= 1'b1;
          end
        end
        S_CALC: begin
          // The new generation always goes into the bank not on display
          if (r_sel) r_bank0[r_row] <= w_new;
          else       r_bank1[r_row] <= w_new;
          r_equal <= r_equal & (w_new == w_mid);
          r_row   <= w_last ? '0 : r_row + AW'(1);
        end
        S_COMMIT: begin
          r_sel      <= ~r_sel;
          r_gen      <= r_gen + 16'd1;
          r_stable   <= r_equal;
          r_load_ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Display read port; addresses past the last row read as empty
  always_comb begin
    rd_row = '0;
    if ({1'b0, rd_addr} < (AW+1)'(HEIGHT)) begin
      rd_row = w_cur[rd_addr];
    end
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign stable     = r_stable;
  assign gen_count  = r_gen;

endmodule

// File: tb/tb_life_grid_stepper.sv
// Bench for life_grid_stepper (8x8). Stimulus pushes the expected grid,
// generation count and stable flag for each step; a monitor pops one entry
// per done pulse and sweeps the read port. Honours LIFE_WRAP_EN for the
// edge pattern.
module tb_life_grid_stepper;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 3;
  localparam int G  = W * H;
  localparam int EW = G + 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_row;
  logic          step;
  logic [8:0]    rule_birth;
  logic [8:0]    rule_survive;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_row;
  logic          busy;
  logic          done;
  logic          stable;
  logic [15:0]   gen_count;

  logic [AW-1:0] stim_addr;
  logic [AW-1:0] mon_addr;
  logic          mon_active;
  assign rd_addr = mon_active ? mon_addr : stim_addr;

  int            checks    = 0;
  int            errors    = 0;
  int            done_seen = 0;
  logic [15:0]   gen_model = '0;
  logic [EW-1:0] exp_q[$];

  life_grid_stepper #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_row(load_row),
    .step(step), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .rd_addr(rd_addr), .rd_row(rd_row),
    .busy(busy), .done(done), .stable(stable), .gen_count(gen_count)
  );

  // Clock
  always #10 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [G-1:0] grid8(input logic [7:0] r0, r1, r2, r3,
                                          input logic [7:0] r4, r5, r6, r7);
    return {r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  // Monitor: on each done pulse, compare the whole grid and status
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (done === 1'b1) begin
      done_seen++;
      check("done_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_active = 1'b1;
        for (int r = 0; r < H; r++) begin
          mon_addr = AW'(r);
          #1;
          check($sformatf("row%0d_gen%0d", r, e[G+16:G+1]), rd_row, e[r*W +: W]);
        end
        mon_active = 1'b0;
        check("gen_count", gen_count, e[G+16:G+1]);
        check("stable", stable, e[G]);
      end
    end
  end

  // Driver: load a full grid starting at row 0
  task automatic load_grid(input logic [G-1:0] g);
    for (int r = 0; r < H; r++) begin
      load_valid = 1'b1;
      load_row   = g[r*W +: W];
      step       = 1'b0;
      #1;
      check("load_ready_idle", load_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
  endtask

  // Driver: issue one step, optionally poke the busy DUT, wait for done
  task automatic do_step(input logic [G-1:0] eg, input logic es,
                         input logic [8:0] b, input logic [8:0] s,
                         input bit meddle, input logic [W-1:0] old3);
    int lat;
    gen_model    = gen_model + 16'd1;
    exp_q.push_back({gen_model, es, eg});
    rule_birth   = b;
    rule_survive = s;
    step         = 1'b1;
    load_valid   = 1'b0;
    @(posedge clk);
    #1;
    step         = 1'b0;
    rule_birth   = ~b;
    rule_survive = ~s;
    lat          = 0;
    check("busy_after_accept", busy, 1'b1);
    if (meddle) begin
      for (int i = 0; i < 3; i++) begin
        stim_addr  = AW'(3);
        load_valid = 1'b1;
        load_row   = '1;
        step       = 1'b1;
        #1;
        check("load_ready_busy", load_ready, 1'b0);
        check("old_gen_row3", rd_row, old3);
        @(posedge clk);
        #1;
        lat++;
      end
    end
    load_valid = 1'b0;
    step       = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_latency", lat, H + 1);
    check("busy_at_done", busy, 1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
  endtask

  // Directed sequence
  initial begin
    int d0;
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_row     = '0;
    step         = 1'b0;
    rule_birth   = '0;
    rule_survive = '0;
    stim_addr    = '0;
    mon_addr     = '0;
    mon_active   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_gen", gen_count, 16'd0);
    check("rst_stable", stable, 1'b0);
    for (int r = 0; r < H; r++) begin
      stim_addr = AW'(r);
      #1;
      check($sformatf("rst_row%0d", r), rd_row, 8'h00);
    end

    // Blinker, B3/S23, two generations
    load_grid(grid8(8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00));
    do_step(grid8(8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00), 1'b0,
            9'h008, 9'h00C, 1'b0, 8'h00);
    do_step(grid8(8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0,
            9'h008, 9'h00C, 1'b0, 8'h00);

    // Block: still life
    load_grid(grid8(8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00));
    do_step(grid8(8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00), 1'b1,
            9'h008, 9'h00C, 1'b0, 8'h00);

    // B1/S-none on a single cell: ring of eight births, centre dies
    load_grid(grid8(8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00));
    do_step(grid8(8'h00, 8'h00, 8'h1C, 8'h14, 8'h1C, 8'h00, 8'h00, 8'h00), 1'b0,
            9'h002, 9'h000, 1'b0, 8'h00);

    // Corner cells: die when isolated, form a block on a torus
    load_grid(grid8(8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81));
`ifdef LIFE_WRAP_EN
    do_step(grid8(8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81), 1'b1,
            9'h008, 9'h00C, 1'b0, 8'h00);
`else
    do_step('0, 1'b0, 9'h008, 9'h00C, 1'b0, 8'h00);
`endif

    // Load and step attempts while busy are dropped; old generation shown
    load_grid(grid8(8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00));
    do_step(grid8(8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00), 1'b0,
            9'h008, 9'h00C, 1'b1, 8'h1C);

    // Reset while computing row 4
    d0           = done_seen;
    rule_birth   = 9'h008;
    rule_survive = 9'h00C;
    step         = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("busy_in_reset", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    gen_model = '0;
    check("midrst_gen", gen_count, 16'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_stable", stable, 1'b0);
    for (int r = 0; r < H; r++) begin
      stim_addr = AW'(r);
      #1;
      check($sformatf("midrst_row%0d", r), rd_row, 8'h00);
    end
    repeat (H + 4) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen, d0);

    // Load and step together: load wins, no step starts
    load_valid = 1'b1;
    step       = 1'b1;
    load_row   = 8'h5A;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    step       = 1'b0;
    check("tie_busy", busy, 1'b0);
    stim_addr = AW'(0);
    #1;
    check("tie_row0", rd_row, 8'h5A);
    stim_addr = AW'(1);
    #1;
    check("tie_row1", rd_row, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("tie_busy_later", busy, 1'b0);
    check("tie_gen", gen_count, 16'd0);
    check("tie_no_done", done_seen, d0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
